lrmode_key_filter: RTL and testbench

Conditions the raw front-panel remote/local selector switch for the local/remote mode controller. It synchronises the asynchronous switch level, rejects bounce and glitches with a debounce state machine, and drives the `key_status` / `key_valid` pair that the mode controller uses to derive `pc_ch_mode`. It also keeps a saturating count of rejected transitions for debug readout.

---
 rtl/lrmode_key_filter_pkg.sv | 11 +
 rtl/lrmode_key_filter_sync.sv | 15 +
 rtl/lrmode_key_filter.sv | 65 ++++++
 tb/tb_lrmode_key_filter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/lrmode_key_filter_pkg.sv
// lrmode_key_filter_pkg: shared key-filter state encodings and default debounce constants
package lrmode_key_filter_pkg;
    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_STABLE = 2'd1,
        ST_CHECK  = 2'd2
    } key_state_t;
    localparam int KEY_DEB_CYCLES = 1_000_000;
    localparam int KEY_CNT_W = 20;
    localparam int KEY_GLITCH_W = 8;
endpackage

// File: rtl/lrmode_key_filter_sync.sv
// sync_2ff: two-flop synchroniser for a single asynchronous panel input
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge clk_sys) begin
        if (!rst_n) {q, meta} <= {RST_VAL, RST_VAL};
        else        {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/lrmode_key_filter.sv
// lrmode_key_filter: debounces the remote/local selector and counts rejected transitions
module lrmode_key_filter
    import lrmode_key_filter_pkg::*;
#(
    parameter int U_DLY      = 1,
    parameter int DEB_CYCLES = KEY_DEB_CYCLES,
    parameter int CNT_W      = KEY_CNT_W
) (
    input  logic                    clk_sys,
    input  logic                    rst_n,
    input  logic                    key_in,
    output logic                    key_status,
    output logic                    key_valid,
    output logic [KEY_GLITCH_W-1:0] key_glitch_cnt
);
    localparam int unused_u_dly = U_DLY;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
    key_state_t       state, nxt;
    logic             key_s, key_d, changed, diff, at_last, load, reject;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d       (key_in),
        .q       (key_s)
    );
    assign changed = key_s != key_d;
    assign diff    = key_s != key_status;
    assign at_last = cnt == LAST;
    always_ff @(posedge clk_sys) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= nxt;
    end
    always_comb begin
        nxt = ST_INIT;
        case (state)
            ST_INIT:   nxt = (!changed && at_last) ? ST_STABLE : ST_INIT;
            ST_STABLE: nxt = diff ? ST_CHECK : ST_STABLE;
            ST_CHECK:  nxt = (diff && !at_last) ? ST_CHECK : ST_STABLE;
            default:   nxt = ST_INIT;
        endcase
    end
    // Illegal encodings fall through every term below, so cnt clears on recovery.
    always_comb begin
        load    = (state == ST_INIT && !changed && at_last) || (state == ST_CHECK && diff && at_last);
        reject  = state == ST_CHECK && !diff;
        cnt_nxt = ((state == ST_INIT && !changed && !at_last) || (state == ST_CHECK && diff && !at_last)) ? cnt + 1'b1
                : (state == ST_STABLE && diff) ? CNT_W'(1) : '0;
    end
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            cnt            <= '0;
            key_d          <= 1'b1;
            key_status     <= 1'b1;
            key_valid      <= 1'b0;
            key_glitch_cnt <= '0;
        end else begin
            cnt       <= cnt_nxt;
            key_d     <= key_s;
            key_valid <= load;
            if (load) key_status <= key_s;
            if (reject && key_glitch_cnt != '1) key_glitch_cnt <= key_glitch_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_lrmode_key_filter.sv
// tb_lrmode_key_filter: directed checks of init, toggle, glitch, boundary, bounce and mid-CHECK reset
module tb_lrmode_key_filter;
    logic       clk_sys = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_in = 1'b0;
    logic       key_status, key_valid;
    logic [7:0] key_glitch_cnt;
    int         checks = 0;
    int         errors = 0;
    int         vcount = 0;
    lrmode_key_filter #(.U_DLY(1), .DEB_CYCLES(16), .CNT_W(5)) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .key_in         (key_in),
        .key_status     (key_status),
        .key_valid      (key_valid),
        .key_glitch_cnt (key_glitch_cnt)
    );
    always #5 clk_sys = ~clk_sys;
    always @(negedge clk_sys) if (key_valid === 1'b1) vcount++;
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    initial begin
        step(3);
        chk("rst_status", 32'(key_status), 1);
        chk("rst_valid", 32'(key_valid), 0);
        chk("rst_glitch", 32'(key_glitch_cnt), 0);
        rst_n = 1'b1;
        step(18);
        chk("init_hold_status", 32'(key_status), 1);
        chk("init_no_valid", 32'(vcount), 0);
        step(1);
        chk("init_load_status", 32'(key_status), 0);
        chk("init_load_valid", 32'(key_valid), 1);
        step(1);
        chk("init_valid_drop", 32'(key_valid), 0);
        chk("init_vcount", 32'(vcount), 1);
        key_in = 1'b1;
        step(17);
        chk("toggle_pre_status", 32'(key_status), 0);
        chk("toggle_pre_valid", 32'(key_valid), 0);
        step(1);
        chk("toggle_status", 32'(key_status), 1);
        chk("toggle_valid", 32'(key_valid), 1);
        step(1);
        chk("toggle_valid_drop", 32'(key_valid), 0);
        key_in = 1'b0;
        step(10);
        key_in = 1'b1;
        step(5);
        chk("glitch10_status", 32'(key_status), 1);
        chk("glitch10_cnt", 32'(key_glitch_cnt), 1);
        chk("glitch10_vcount", 32'(vcount), 2);
        key_in = 1'b0;
        step(15);
        key_in = 1'b1;
        step(5);
        chk("bound15_status", 32'(key_status), 1);
        chk("bound15_cnt", 32'(key_glitch_cnt), 2);
        chk("bound15_vcount", 32'(vcount), 2);
        key_in = 1'b0;
        step(16);
        key_in = 1'b1;
        step(1);
        chk("bound16_pre_status", 32'(key_status), 1);
        step(1);
        chk("bound16_status", 32'(key_status), 0);
        chk("bound16_valid", 32'(key_valid), 1);
        step(15);
        chk("bound16_back_pre", 32'(key_status), 0);
        step(1);
        chk("bound16_back_status", 32'(key_status), 1);
        chk("bound16_back_valid", 32'(key_valid), 1);
        chk("bound16_glitch", 32'(key_glitch_cnt), 2);
        for (int i = 0; i < 300; i++) begin
            key_in = 1'b0;
            step(3);
            key_in = 1'b1;
            step(3);
        end
        chk("bounce_sat", 32'(key_glitch_cnt), 255);
        chk("bounce_status", 32'(key_status), 1);
        chk("bounce_vcount", 32'(vcount), 4);
        key_in = 1'b0;
        step(17);
        chk("bounce_final_pre", 32'(key_status), 1);
        step(1);
        chk("bounce_final_status", 32'(key_status), 0);
        chk("bounce_final_valid", 32'(key_valid), 1);
        step(5);
        chk("bounce_final_vcount", 32'(vcount), 5);
        chk("bounce_sat_hold", 32'(key_glitch_cnt), 255);
        key_in = 1'b1;
        step(10);
        chk("midchk_pending", 32'(key_status), 0);
        rst_n = 1'b0;
        step(1);
        chk("midrst_status", 32'(key_status), 1);
        chk("midrst_valid", 32'(key_valid), 0);
        chk("midrst_glitch", 32'(key_glitch_cnt), 0);
        rst_n = 1'b1;
        step(15);
        chk("reinit_pre_valid", 32'(key_valid), 0);
        chk("reinit_pre_vcount", 32'(vcount), 5);
        step(1);
        chk("reinit_status", 32'(key_status), 1);
        chk("reinit_valid", 32'(key_valid), 1);
        step(1);
        chk("reinit_valid_drop", 32'(key_valid), 0);
        chk("reinit_vcount", 32'(vcount), 6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
